// File: rtl/mips_mc_control.sv
// Multicycle MIPS main controller with ALU decoder: one registered state, Moore-decoded controls,
// memory-ready stalls and a retired-instruction counter.
module mips_mc_control #(
    parameter bit          MEM_WAIT_EN = 1'b1,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [5:0]       opcode_i,
    input  logic [5:0]       funct_i,
    input  logic             zero_i,
    input  logic             mem_ready_i,
    output logic             mem_write_o,
    output logic             iord_o,
    output logic             ir_write_o,
    output logic             pc_en_o,
    output logic             reg_dst_o,
    output logic             mem_to_reg_o,
    output logic             reg_write_o,
    output logic             alu_src_a_o,
    output logic [1:0]       alu_src_b_o,
    output logic [2:0]       alu_control_o,
    output logic [1:0]       pc_src_o,
    output logic             illegal_o,
    output logic [CNT_W-1:0] instr_count_o
);

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpJ     = 6'b000010;

    localparam logic [2:0] AluAdd = 3'b010;
    localparam logic [2:0] AluSub = 3'b110;
    localparam logic [2:0] AluAnd = 3'b000;
    localparam logic [2:0] AluOr  = 3'b001;
    localparam logic [2:0] AluSlt = 3'b111;

    typedef enum logic [3:0] {
        StFetch, StDecode, StMemAdr, StMemRd, StMemWb, StMemWr,
        StExecute, StAluWb, StBranch, StAddiEx, StAddiWb, StJump
    } state_e;

    state_e           state_q, state_d;
    logic             is_store_q, is_store_d;
    logic [CNT_W-1:0] count_q;
    logic             retire;
    logic             mem_rdy;
    logic             pc_write, branch, illegal, ir_write, mem_write, reg_write;

    assign mem_rdy = MEM_WAIT_EN ? mem_ready_i : 1'b1;

    always_comb begin
        state_d       = state_q;
        is_store_d    = is_store_q;
        retire        = 1'b0;
        pc_write      = 1'b0;
        branch        = 1'b0;
        illegal       = 1'b0;
        ir_write      = 1'b0;
        mem_write     = 1'b0;
        reg_write     = 1'b0;
        iord_o        = 1'b0;
        reg_dst_o     = 1'b0;
        mem_to_reg_o  = 1'b0;
        alu_src_a_o   = 1'b0;
        alu_src_b_o   = 2'b00;
        alu_control_o = AluAnd;
        pc_src_o      = 2'b00;
        case (state_q)
            StFetch: begin
                alu_src_b_o   = 2'b01;
                alu_control_o = AluAdd;
                ir_write      = mem_rdy;
                pc_write      = mem_rdy;
                if (mem_rdy) state_d = StDecode;
            end
            StDecode: begin
                alu_src_b_o   = 2'b11;
                alu_control_o = AluAdd;
                case (opcode_i)
                    OpLw: begin
                        state_d    = StMemAdr;
                        is_store_d = 1'b0;
                    end
                    OpSw: begin
                        state_d    = StMemAdr;
                        is_store_d = 1'b1;
                    end
                    OpRtype: state_d = StExecute;
                    OpBeq:   state_d = StBranch;
                    OpAddi:  state_d = StAddiEx;
                    OpJ:     state_d = StJump;
                    default: begin
                        illegal = 1'b1;
                        state_d = StFetch;
                    end
                endcase
            end
            StMemAdr: begin
                alu_src_a_o   = 1'b1;
                alu_src_b_o   = 2'b10;
                alu_control_o = AluAdd;
                // Load/store choice was latched in decode; the IR opcode is not re-read here.
                state_d       = is_store_q ? StMemWr : StMemRd;
            end
            StMemRd: begin
                iord_o = 1'b1;
                if (mem_rdy) state_d = StMemWb;
            end
            StMemWb: begin
                mem_to_reg_o = 1'b1;
                reg_write    = 1'b1;
                retire       = 1'b1;
                state_d      = StFetch;
            end
            StMemWr: begin
                iord_o    = 1'b1;
                mem_write = 1'b1;
                if (mem_rdy) begin
                    retire  = 1'b1;
                    state_d = StFetch;
                end
            end
            StExecute: begin
                alu_src_a_o = 1'b1;
                state_d     = StAluWb;
                case (funct_i)
                    6'b100000: alu_control_o = AluAdd;
                    6'b100010: alu_control_o = AluSub;
                    6'b100100: alu_control_o = AluAnd;
                    6'b100101: alu_control_o = AluOr;
                    6'b101010: alu_control_o = AluSlt;
                    default: begin
                        alu_control_o = AluAdd;
                        illegal       = 1'b1;
                        state_d       = StFetch;
                    end
                endcase
            end
            StAluWb: begin
                reg_dst_o = 1'b1;
                reg_write = 1'b1;
                retire    = 1'b1;
                state_d   = StFetch;
            end
            StBranch: begin
                alu_src_a_o   = 1'b1;
                alu_control_o = AluSub;
                pc_src_o      = 2'b01;
                branch        = 1'b1;
                retire        = 1'b1;
                state_d       = StFetch;
            end
            StAddiEx: begin
                alu_src_a_o   = 1'b1;
                alu_src_b_o   = 2'b10;
                alu_control_o = AluAdd;
                state_d       = StAddiWb;
            end
            StAddiWb: begin
                reg_write = 1'b1;
                retire    = 1'b1;
                state_d   = StFetch;
            end
            StJump: begin
                pc_src_o = 2'b10;
                pc_write = 1'b1;
                retire   = 1'b1;
                state_d  = StFetch;
            end
            default: state_d = StFetch;
        endcase
    end

    // Strobes are masked by reset so nothing is written while reset is held.
    assign mem_write_o   = mem_write & ~rst_i;
    assign ir_write_o    = ir_write & ~rst_i;
    assign reg_write_o   = reg_write & ~rst_i;
    assign pc_en_o       = (pc_write | (branch & zero_i)) & ~rst_i;
    assign illegal_o     = illegal & ~rst_i;
    assign instr_count_o = count_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= StFetch;
            is_store_q <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            is_store_q <= is_store_d;
            if (retire) count_q <= count_q + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_mips_mc_control.sv
// Directed bench for mips_mc_control: walks each instruction class through its states and
// compares the full control vector and retire count against hand-derived values.
module tb_mips_mc_control;

    logic       clk, rst, zero, ready;
    logic [5:0] opcode, funct;
    logic       mem_write, iord, ir_write, pc_en, reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0] alu_src_b, pc_src;
    logic [2:0] alu_control;
    logic       illegal;
    logic [3:0] count;

    int checks = 0;
    int errors = 0;
    int irw_seen = 0;
    int rw_seen = 0;
    int irw0, rw0;
    logic [3:0] exp_cnt;

    logic [15:0] ctl;
    logic [15:0] f_rdy, f_wait, dec, dec_ill, memadr, memrd, memwb, memwr;
    logic [15:0] exec_add, exec_ill, aluwb, br1, br0, addiwb, jump;

    logic [5:0] fn_tab [5] = '{6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100000};
    logic [2:0] alu_tab [5] = '{3'b110, 3'b000, 3'b001, 3'b111, 3'b010};

    mips_mc_control #(
        .MEM_WAIT_EN (1'b1),
        .CNT_W       (4)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .opcode_i      (opcode),
        .funct_i       (funct),
        .zero_i        (zero),
        .mem_ready_i   (ready),
        .mem_write_o   (mem_write),
        .iord_o        (iord),
        .ir_write_o    (ir_write),
        .pc_en_o       (pc_en),
        .reg_dst_o     (reg_dst),
        .mem_to_reg_o  (mem_to_reg),
        .reg_write_o   (reg_write),
        .alu_src_a_o   (alu_src_a),
        .alu_src_b_o   (alu_src_b),
        .alu_control_o (alu_control),
        .pc_src_o      (pc_src),
        .illegal_o     (illegal),
        .instr_count_o (count)
    );

    assign ctl = {mem_write, iord, ir_write, pc_en, reg_dst, mem_to_reg, reg_write, alu_src_a,
                  alu_src_b, alu_control, pc_src, illegal};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ir_write) irw_seen <= irw_seen + 1;
        if (reg_write) rw_seen <= rw_seen + 1;
    end

    function automatic logic [15:0] mk(input logic mw, input logic io, input logic irw,
                                       input logic pce, input logic rd, input logic m2r,
                                       input logic rw, input logic sa, input logic [1:0] sb,
                                       input logic [2:0] alu, input logic [1:0] ps,
                                       input logic ill);
        return {mw, io, irw, pce, rd, m2r, rw, sa, sb, alu, ps, ill};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_ctl(input string tag, input logic [15:0] exp);
        chk(tag, 32'(ctl), 32'(exp));
    endtask

    task automatic chk_cnt(input string tag);
        chk(tag, 32'(count), 32'(exp_cnt));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //           mw io irw pce rd m2r rw sa  sb     alu     ps  ill
        f_rdy    = mk(0, 0, 1, 1, 0, 0, 0, 0, 2'b01, 3'b010, 2'b00, 0);
        f_wait   = mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 3'b010, 2'b00, 0);
        dec      = mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 3'b010, 2'b00, 0);
        dec_ill  = mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 3'b010, 2'b00, 1);
        memadr   = mk(0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b010, 2'b00, 0);
        memrd    = mk(0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 2'b00, 0);
        memwb    = mk(0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 3'b000, 2'b00, 0);
        memwr    = mk(1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 2'b00, 0);
        exec_add = mk(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b010, 2'b00, 0);
        exec_ill = mk(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b010, 2'b00, 1);
        aluwb    = mk(0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 3'b000, 2'b00, 0);
        br1      = mk(0, 0, 0, 1, 0, 0, 0, 1, 2'b00, 3'b110, 2'b01, 0);
        br0      = mk(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b110, 2'b01, 0);
        addiwb   = mk(0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 3'b000, 2'b00, 0);
        jump     = mk(0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 3'b000, 2'b10, 0);

        rst = 1'b1; ready = 1'b1; zero = 1'b0; opcode = 6'b000000; funct = 6'b100000;
        exp_cnt = 4'd0;
        tick(); tick();
        chk_ctl("reset_ctl", f_wait);
        chk_cnt("reset_cnt");
        @(negedge clk);
        rst = 1'b0;
        #1;

        // add
        chk_ctl("add_fetch", f_rdy);
        tick(); chk_ctl("add_decode", dec);
        tick(); chk_ctl("add_execute", exec_add);
        tick(); chk_ctl("add_aluwb", aluwb);
        tick(); exp_cnt++; chk_cnt("add_retire"); chk_ctl("add_back_fetch", f_rdy);

        // every legal funct decoded while sitting in EXECUTE
        tick(); tick();
        for (int i = 0; i < 5; i++) begin
            funct = fn_tab[i];
            #1;
            chk_ctl($sformatf("exec_funct_%0d", i),
                    mk(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, alu_tab[i], 2'b00, 0));
        end
        tick(); chk_ctl("rtype_aluwb", aluwb);
        tick(); exp_cnt++; chk_cnt("rtype_retire");

        // lw with 2 fetch stalls and 3 read stalls: 10 cycles
        irw0 = irw_seen;
        opcode = 6'b100011; ready = 1'b0;
        #1; chk_ctl("lw_fetch_wait0", f_wait);
        tick(); chk_ctl("lw_fetch_wait1", f_wait);
        tick(); ready = 1'b1; #1; chk_ctl("lw_fetch_rdy", f_rdy);
        tick(); chk_ctl("lw_decode", dec);
        tick(); chk_ctl("lw_memadr", memadr);
        tick(); ready = 1'b0; #1; chk_ctl("lw_memrd_w0", memrd);
        tick(); chk_ctl("lw_memrd_w1", memrd);
        tick(); chk_ctl("lw_memrd_w2", memrd);
        tick(); ready = 1'b1; #1; chk_ctl("lw_memrd_rdy", memrd);
        tick(); chk_ctl("lw_memwb", memwb);
        tick(); exp_cnt++; chk_cnt("lw_retire"); chk_ctl("lw_back_fetch", f_rdy);
        chk("lw_irwrite_pulses", 32'(irw_seen - irw0), 32'd1);

        // beq taken; pc_en follows zero combinationally in BRANCH
        opcode = 6'b000100; zero = 1'b1;
        tick(); chk_ctl("beq_t_decode", dec);
        tick(); chk_ctl("beq_t_branch", br1);
        zero = 1'b0; #1; chk_ctl("beq_zero_drop", br0);
        zero = 1'b1;
        tick(); exp_cnt++; chk_cnt("beq_t_retire");
        // beq not taken
        zero = 1'b0;
        tick(); chk_ctl("beq_n_decode", dec);
        tick(); chk_ctl("beq_n_branch", br0);
        tick(); exp_cnt++; chk_cnt("beq_n_retire");

        // illegal opcode then illegal funct
        rw0 = rw_seen;
        opcode = 6'b111111;
        #1; chk_ctl("illop_fetch", f_rdy);
        tick(); chk_ctl("illop_decode", dec_ill);
        tick(); chk_ctl("illop_back_fetch", f_rdy); chk_cnt("illop_no_retire");
        opcode = 6'b000000; funct = 6'b000111;
        tick(); chk_ctl("illfn_decode", dec);
        tick(); chk_ctl("illfn_execute", exec_ill);
        tick(); chk_ctl("illfn_back_fetch", f_rdy); chk_cnt("illfn_no_retire");
        chk("illegal_no_regwrite", 32'(rw_seen - rw0), 32'd0);

        // addi
        opcode = 6'b001000;
        tick(); chk_ctl("addi_decode", dec);
        tick(); chk_ctl("addi_ex", memadr);
        tick(); chk_ctl("addi_wb", addiwb);
        tick(); exp_cnt++; chk_cnt("addi_retire");

        // sw with one stall; opcode change after decode must be ignored
        opcode = 6'b101011;
        tick(); chk_ctl("sw_decode", dec);
        tick(); chk_ctl("sw_memadr", memadr);
        opcode = 6'b100011;
        tick(); ready = 1'b0; #1; chk_ctl("sw_memwr_wait", memwr);
        tick(); ready = 1'b1; #1; chk_ctl("sw_memwr_rdy", memwr);
        tick(); exp_cnt++; chk_cnt("sw_retire"); chk_ctl("sw_back_fetch", f_rdy);

        // reset mid-store: strobe drops with no clock edge
        opcode = 6'b101011;
        tick(); tick();
        tick(); ready = 1'b0; #1; chk_ctl("rst_pre_memwr", memwr);
        rst = 1'b1; #1;
        chk_ctl("rst_async_ctl", f_wait);
        exp_cnt = 4'd0;
        chk_cnt("rst_async_cnt");
        tick(); chk_ctl("rst_held_ctl", f_wait);
        @(negedge clk);
        rst = 1'b0; ready = 1'b1; #1;
        chk_ctl("rst_release_fetch", f_rdy);
        chk_cnt("rst_release_cnt");

        // 16 jumps: 4-bit count wraps 15 -> 0
        opcode = 6'b000010;
        for (int i = 0; i < 16; i++) begin
            tick(); chk_ctl($sformatf("j%0d_decode", i), dec);
            tick(); chk_ctl($sformatf("j%0d_jump", i), jump);
            tick(); exp_cnt++; chk_cnt($sformatf("j%0d_count", i));
        end
        chk("wrap_to_zero", 32'(count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
